// File: rtl/aurora_rx_frame_checker_if.sv
// Aurora user RX AXI-stream bundle (no tready: every valid beat is consumed).
interface aurora_rx_frame_checker_if #(
  parameter int unsigned DATA_WIDTH = 32
);
  logic [DATA_WIDTH-1:0]   m_axi_rx_tdata;
  logic [DATA_WIDTH/8-1:0] m_axi_rx_tkeep;
  logic                    m_axi_rx_tlast;
  logic                    m_axi_rx_tvalid;

  modport master (
    output m_axi_rx_tdata,
    output m_axi_rx_tkeep,
    output m_axi_rx_tlast,
    output m_axi_rx_tvalid
  );

  modport slave (
    input m_axi_rx_tdata,
    input m_axi_rx_tkeep,
    input m_axi_rx_tlast,
    input m_axi_rx_tvalid
  );
endinterface

// File: rtl/aurora_rx_frame_checker.sv
// Aurora RX frame checker: validates framed test traffic (tag, sequence, payload, keep, last)
// and keeps saturating good/error/sequence-error counters for loopback bring-up.
module aurora_rx_frame_checker #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned FRAME_LEN  = 256,
  parameter logic [15:0] HEAD_TAG   = 16'hA5A5,
  parameter int unsigned CNT_WIDTH  = 32
) (
  input  logic                     sys_clk_i,
  input  logic                     rst_n_i,
  input  logic                     channel_up,
  input  logic                     check_en_i,
  input  logic                     clr_i,
  aurora_rx_frame_checker_if.slave rx,
  output logic                     frame_ok_o,
  output logic [CNT_WIDTH-1:0]     frame_cnt_o,
  output logic [CNT_WIDTH-1:0]     err_cnt_o,
  output logic [CNT_WIDTH-1:0]     seq_err_cnt_o,
  output logic                     err_flag_o,
  output logic [1:0]               state_o
);

  localparam int unsigned KEEP_W   = DATA_WIDTH / 8;
  localparam logic [15:0] LAST_IDX = 16'(FRAME_LEN - 1);

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StHead = 2'd1,
    StBody = 2'd2,
    StDrop = 2'd3
  } state_e;

  state_e               r_state, w_state_d;
  logic [15:0]          r_idx, w_idx_d;
  logic [15:0]          r_rx_seq, w_rx_seq_d;
  logic [15:0]          r_exp_seq, w_exp_seq_d;
  logic                 r_seq_synced, w_synced_d;
  logic [CNT_WIDTH-1:0] r_frame_cnt, r_err_cnt, r_seq_err_cnt;
  logic                 r_err_flag, r_frame_ok;

  logic w_active, w_keep_ok, w_hdr_bad, w_body_bad, w_last_exp;
  logic w_err_inc, w_seq_err_inc, w_frame_inc;

  assign w_active   = channel_up & check_en_i;
  assign w_keep_ok  = (rx.m_axi_rx_tkeep == {KEEP_W{1'b1}});
  assign w_hdr_bad  = (rx.m_axi_rx_tdata[31:16] != HEAD_TAG) | ~w_keep_ok | rx.m_axi_rx_tlast;
  assign w_last_exp = (r_idx == LAST_IDX);
  assign w_body_bad = (rx.m_axi_rx_tdata != {r_rx_seq, r_idx}) | ~w_keep_ok |
                      (rx.m_axi_rx_tlast != w_last_exp);

  always_comb begin
    w_state_d     = r_state;
    w_idx_d       = r_idx;
    w_rx_seq_d    = r_rx_seq;
    w_exp_seq_d   = r_exp_seq;
    w_synced_d    = r_seq_synced;
    w_err_inc     = 1'b0;
    w_seq_err_inc = 1'b0;
    w_frame_inc   = 1'b0;

    if (!w_active) begin
      // Only a frame already past its header counts as aborted.
      w_state_d = StIdle;
      w_err_inc = (r_state == StBody);
    end else begin
      unique case (r_state)
        StIdle: w_state_d = StHead;
        StHead: begin
          if (rx.m_axi_rx_tvalid) begin
            if (w_hdr_bad) begin
              w_err_inc = 1'b1;
              w_state_d = rx.m_axi_rx_tlast ? StHead : StDrop;
            end else begin
              w_rx_seq_d    = rx.m_axi_rx_tdata[15:0];
              w_idx_d       = 16'd1;
              w_state_d     = StBody;
              w_seq_err_inc = r_seq_synced && (rx.m_axi_rx_tdata[15:0] != r_exp_seq);
              w_exp_seq_d   = rx.m_axi_rx_tdata[15:0] + 16'd1;
              w_synced_d    = 1'b1;
            end
          end
        end
        StBody: begin
          if (rx.m_axi_rx_tvalid) begin
            if (w_body_bad) begin
              w_err_inc = 1'b1;
              w_state_d = rx.m_axi_rx_tlast ? StHead : StDrop;
            end else if (rx.m_axi_rx_tlast) begin
              w_frame_inc = 1'b1;
              w_state_d   = StHead;
            end else begin
              w_idx_d = r_idx + 16'd1;
            end
          end
        end
        StDrop: begin
          if (rx.m_axi_rx_tvalid && rx.m_axi_rx_tlast) begin
            w_state_d = StHead;
          end
        end
        default: w_state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge sys_clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_state   <= StIdle;
      r_idx     <= '0;
      r_rx_seq  <= '0;
      r_exp_seq <= '0;
    end else begin
      r_state   <= w_state_d;
      r_idx     <= w_idx_d;
      r_rx_seq  <= w_rx_seq_d;
      r_exp_seq <= w_exp_seq_d;
    end
  end

  // Clear takes priority over any same-cycle increment; FSM state is left alone.
  always_ff @(posedge sys_clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_seq_synced  <= 1'b0;
      r_frame_cnt   <= '0;
      r_err_cnt     <= '0;
      r_seq_err_cnt <= '0;
      r_err_flag    <= 1'b0;
      r_frame_ok    <= 1'b0;
    end else begin
      r_frame_ok <= w_frame_inc;
      if (clr_i) begin
        r_seq_synced  <= 1'b0;
        r_frame_cnt   <= '0;
        r_err_cnt     <= '0;
        r_seq_err_cnt <= '0;
        r_err_flag    <= 1'b0;
      end else begin
        r_seq_synced <= w_synced_d;
        if (w_frame_inc && !(&r_frame_cnt)) begin
          r_frame_cnt <= r_frame_cnt + CNT_WIDTH'(1);
        end
        if (w_err_inc && !(&r_err_cnt)) begin
          r_err_cnt <= r_err_cnt + CNT_WIDTH'(1);
        end
        if (w_seq_err_inc && !(&r_seq_err_cnt)) begin
          r_seq_err_cnt <= r_seq_err_cnt + CNT_WIDTH'(1);
        end
        if (w_err_inc || w_seq_err_inc) begin
          r_err_flag <= 1'b1;
        end
      end
    end
  end

  assign frame_ok_o    = r_frame_ok;
  assign frame_cnt_o   = r_frame_cnt;
  assign err_cnt_o     = r_err_cnt;
  assign seq_err_cnt_o = r_seq_err_cnt;
  assign err_flag_o    = r_err_flag;
  assign state_o       = r_state;

endmodule

// File: tb/tb_aurora_rx_frame_checker.sv
// Directed bench for aurora_rx_frame_checker (FRAME_LEN=4, CNT_WIDTH=4): vector table
// followed by hand-written abort, reset, header-error and saturation sequences.
module tb_aurora_rx_frame_checker;

  localparam int unsigned CW = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          channel_up, check_en, clr;
  logic          frame_ok, err_flag;
  logic [CW-1:0] frame_cnt, err_cnt, seq_err_cnt;
  logic [1:0]    state;

  int checks = 0;
  int errors = 0;

  aurora_rx_frame_checker_if #(.DATA_WIDTH(32)) rx_if ();

  aurora_rx_frame_checker #(
    .DATA_WIDTH(32),
    .FRAME_LEN (4),
    .HEAD_TAG  (16'hA5A5),
    .CNT_WIDTH (CW)
  ) dut (
    .sys_clk_i    (clk),
    .rst_n_i      (rst_n),
    .channel_up   (channel_up),
    .check_en_i   (check_en),
    .clr_i        (clr),
    .rx           (rx_if.slave),
    .frame_ok_o   (frame_ok),
    .frame_cnt_o  (frame_cnt),
    .err_cnt_o    (err_cnt),
    .seq_err_cnt_o(seq_err_cnt),
    .err_flag_o   (err_flag),
    .state_o      (state)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0]   data;
    logic          last;
    logic          valid;
    logic          clr;
    logic [1:0]    st;
    logic          ok;
    logic [CW-1:0] f;
    logic [CW-1:0] e;
    logic [CW-1:0] s;
    logic          fl;
  } vec_t;

  vec_t tbl[$];

  function automatic void add(input logic [31:0] d, input logic l, input logic v, input logic c,
                              input logic [1:0] st, input logic ok, input int f, input int e,
                              input int s, input logic fl);
    vec_t x;
    x.data = d; x.last = l; x.valid = v; x.clr = c;
    x.st = st; x.ok = ok; x.f = CW'(f); x.e = CW'(e); x.s = CW'(s); x.fl = fl;
    tbl.push_back(x);
  endfunction

  // Good 4-word frame; e/s/fl are the values expected once the header has been taken.
  function automatic void add_frame(input logic [15:0] seq, input int f, input int e,
                                    input int s, input logic fl);
    add({16'hA5A5, seq}, 1'b0, 1'b1, 1'b0, 2'd2, 1'b0, f, e, s, fl);
    add({seq, 16'd1},    1'b0, 1'b1, 1'b0, 2'd2, 1'b0, f, e, s, fl);
    add({seq, 16'd2},    1'b0, 1'b1, 1'b0, 2'd2, 1'b0, f, e, s, fl);
    add({seq, 16'd3},    1'b1, 1'b1, 1'b0, 2'd1, 1'b1, f + 1, e, s, fl);
  endfunction

  task automatic step(input logic [31:0] d, input logic l, input logic v, input logic [3:0] k,
                      input logic c);
    rx_if.m_axi_rx_tdata  = d;
    rx_if.m_axi_rx_tlast  = l;
    rx_if.m_axi_rx_tvalid = v;
    rx_if.m_axi_rx_tkeep  = k;
    clr                   = c;
    @(posedge clk);
    #1;
    rx_if.m_axi_rx_tvalid = 1'b0;
    clr                   = 1'b0;
  endtask

  task automatic idle_step();
    step(32'h0, 1'b0, 1'b0, 4'hF, 1'b0);
  endtask

  task automatic send_frame(input logic [15:0] seq);
    step({16'hA5A5, seq}, 1'b0, 1'b1, 4'hF, 1'b0);
    for (int k = 1; k < 4; k++) begin
      step({seq, 16'(k)}, (k == 3), 1'b1, 4'hF, 1'b0);
    end
  endtask

  task automatic check(input string name, input logic [1:0] st, input logic ok, input int f,
                       input int e, input int s, input logic fl);
    checks++;
    if ({state, frame_ok, frame_cnt, err_cnt, seq_err_cnt, err_flag} !==
        {st, ok, CW'(f), CW'(e), CW'(s), fl}) begin
      errors++;
      $display("FAIL %s: got st=%0d ok=%0d frm=%0d err=%0d seq=%0d flag=%0d, want st=%0d ok=%0d frm=%0d err=%0d seq=%0d flag=%0d",
               name, state, frame_ok, frame_cnt, err_cnt, seq_err_cnt, err_flag,
               st, ok, f, e, s, fl);
    end
  endtask

  initial begin
    rst_n = 1'b0; channel_up = 1'b0; check_en = 1'b0; clr = 1'b0;
    rx_if.m_axi_rx_tdata = '0; rx_if.m_axi_rx_tkeep = 4'hF;
    rx_if.m_axi_rx_tlast = 1'b0; rx_if.m_axi_rx_tvalid = 1'b0;

    // Idle -> Head, then three back-to-back frames with gaps
    add(32'h0, 0, 0, 0, 1, 0, 0, 0, 0, 0);
    add(32'hA5A5_0000, 0, 1, 0, 2, 0, 0, 0, 0, 0);
    add(32'h0, 0, 0, 0, 2, 0, 0, 0, 0, 0);
    add(32'h0000_0001, 0, 1, 0, 2, 0, 0, 0, 0, 0);
    add(32'h0000_0002, 0, 1, 0, 2, 0, 0, 0, 0, 0);
    add(32'h0000_0003, 1, 1, 0, 1, 1, 1, 0, 0, 0);
    add(32'hA5A5_0001, 0, 1, 0, 2, 0, 1, 0, 0, 0);
    add(32'h0001_0001, 0, 1, 0, 2, 0, 1, 0, 0, 0);
    add(32'h0, 0, 0, 0, 2, 0, 1, 0, 0, 0);
    add(32'h0001_0002, 0, 1, 0, 2, 0, 1, 0, 0, 0);
    add(32'h0001_0003, 1, 1, 0, 1, 1, 2, 0, 0, 0);
    add_frame(16'h0002, 2, 0, 0, 0);
    // Payload corruption on word 2 -> Drop until tlast
    add(32'h0, 0, 0, 1, 1, 0, 0, 0, 0, 0);
    add(32'hA5A5_0005, 0, 1, 0, 2, 0, 0, 0, 0, 0);
    add(32'h0005_0001, 0, 1, 0, 2, 0, 0, 0, 0, 0);
    add(32'h0005_0007, 0, 1, 0, 3, 0, 0, 1, 0, 1);
    add(32'h0, 0, 0, 0, 3, 0, 0, 1, 0, 1);
    add(32'h0005_0003, 1, 1, 0, 1, 0, 0, 1, 0, 1);
    // Early tlast on word 2 goes straight to Head, next frame counted
    add(32'h0, 0, 0, 1, 1, 0, 0, 0, 0, 0);
    add(32'hA5A5_0005, 0, 1, 0, 2, 0, 0, 0, 0, 0);
    add(32'h0005_0001, 0, 1, 0, 2, 0, 0, 0, 0, 0);
    add(32'h0005_0002, 1, 1, 0, 1, 0, 0, 1, 0, 1);
    add_frame(16'h0006, 0, 1, 0, 1);
    // Sequence gap, resync, and 0xFFFF -> 0x0000 wrap
    add(32'h0, 0, 0, 1, 1, 0, 0, 0, 0, 0);
    add_frame(16'h000A, 0, 0, 0, 0);
    add_frame(16'h000C, 1, 0, 1, 1);
    add_frame(16'hFFFF, 2, 0, 2, 1);
    add_frame(16'h0000, 3, 0, 2, 1);

    repeat (2) @(posedge clk);
    #1;
    check("reset", 2'd0, 1'b0, 0, 0, 0, 1'b0);
    rst_n = 1'b1;
    idle_step();
    check("idle_hold", 2'd0, 1'b0, 0, 0, 0, 1'b0);
    channel_up = 1'b1; check_en = 1'b1;

    for (int i = 0; i < tbl.size(); i++) begin
      step(tbl[i].data, tbl[i].last, tbl[i].valid, 4'hF, tbl[i].clr);
      check($sformatf("vec%0d", i), tbl[i].st, tbl[i].ok, int'(tbl[i].f), int'(tbl[i].e),
            int'(tbl[i].s), tbl[i].fl);
    end

    // channel_up drop mid-body aborts the frame; sync survives
    step(32'h0, 1'b0, 1'b0, 4'hF, 1'b1);
    step(32'hA5A5_00FF, 1'b0, 1'b1, 4'hF, 1'b0);
    step(32'h00FF_0001, 1'b0, 1'b1, 4'hF, 1'b0);
    channel_up = 1'b0;
    idle_step();
    check("body_abort", 2'd0, 1'b0, 0, 1, 0, 1'b1);
    channel_up = 1'b1;
    idle_step();
    check("reenter_head", 2'd1, 1'b0, 0, 1, 0, 1'b1);
    send_frame(16'h0100);
    check("after_abort", 2'd1, 1'b1, 1, 1, 0, 1'b1);

    // Header errors and aborts from Drop/Head that add no count
    step(32'h0, 1'b0, 1'b0, 4'hF, 1'b1);
    step(32'h5A5A_0001, 1'b0, 1'b1, 4'hF, 1'b0);
    check("bad_tag", 2'd3, 1'b0, 0, 1, 0, 1'b1);
    check_en = 1'b0;
    idle_step();
    check("drop_abort", 2'd0, 1'b0, 0, 1, 0, 1'b1);
    check_en = 1'b1;
    idle_step();
    step(32'hA5A5_0002, 1'b0, 1'b1, 4'h7, 1'b0);
    check("bad_keep", 2'd3, 1'b0, 0, 2, 0, 1'b1);
    step(32'h1234_5678, 1'b1, 1'b1, 4'hF, 1'b0);
    check("drop_end", 2'd1, 1'b0, 0, 2, 0, 1'b1);
    check_en = 1'b0;
    idle_step();
    check("head_abort", 2'd0, 1'b0, 0, 2, 0, 1'b1);
    check_en = 1'b1;
    idle_step();

    // Asynchronous reset mid-frame, then unsynced restart
    step(32'hA5A5_0200, 1'b0, 1'b1, 4'hF, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst", 2'd0, 1'b0, 0, 0, 0, 1'b0);
    #1 rst_n = 1'b1;
    idle_step();
    send_frame(16'h0300);
    check("post_rst", 2'd1, 1'b1, 1, 0, 0, 1'b0);

    // Saturation of err_cnt, then clear beating a same-cycle error
    step(32'h0, 1'b0, 1'b0, 4'hF, 1'b1);
    for (int i = 0; i < 16; i++) begin
      step(32'h5A5A_0000, 1'b1, 1'b1, 4'hF, 1'b0);
    end
    check("err_sat", 2'd1, 1'b0, 0, 15, 0, 1'b1);
    step(32'h5A5A_0000, 1'b1, 1'b1, 4'hF, 1'b1);
    check("clr_wins", 2'd1, 1'b0, 0, 0, 0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/aurora_rx_frame_checker.md
Name: aurora_rx_frame_checker

Overview:
- Receive-side checker for the Aurora 8b10b user RX AXI-stream (m_axi_rx_*). It sits per channel beside the wrapper, downstream of the RX user interface, and is the counterpart of the TX frame generator.
- Validates framed test traffic: header tag, sequence continuity, payload pattern, tkeep and tlast placement.
- Exposes saturating frame/error counters and status for loopback and board bring-up.

Parameters:
DATA_WIDTH, 32, RX data width (fixed 32; tkeep width DATA_WIDTH/8)
FRAME_LEN, 256, words per frame including header; legal range 2..65535
HEAD_TAG, 16'hA5A5, expected upper half of header word
CNT_WIDTH, 32, width of all counters

Ports:
sys_clk_i  input  1  Aurora user_clk_out for this channel
rst_n_i  input  1  asynchronous active-low reset (~sys_reset_out)
channel_up  input  1  Aurora channel_up
check_en_i  input  1  enables checking
clr_i  input  1  synchronous clear of counters, sticky flag and sequence sync
m_axi_rx_tdata  input  DATA_WIDTH  RX data
m_axi_rx_tkeep  input  DATA_WIDTH/8  RX byte keep
m_axi_rx_tlast  input  1  RX end of frame
m_axi_rx_tvalid  input  1  RX beat valid (no tready; every valid beat is consumed)
frame_ok_o  output  1  one-cycle pulse per error-free frame
frame_cnt_o  output  CNT_WIDTH  good frames received
err_cnt_o  output  CNT_WIDTH  corrupted frames (header/payload/keep/last/abort)
seq_err_cnt_o  output  CNT_WIDTH  sequence discontinuities
err_flag_o  output  1  sticky, set on any error
state_o  output  2  FSM state (IDLE=0, HEAD=1, BODY=2, DROP=3)

Behaviour:
- Frame format, seq = 16-bit frame number: word 0 = {HEAD_TAG, seq}; word k, for k = 1..FRAME_LEN-1, = {seq, k[15:0]}.
  - tkeep is all ones on every beat.
  - tlast is asserted only on word FRAME_LEN-1.
- Reset: all outputs 0, state IDLE, seq_synced=0, word index 0.
- IDLE → HEAD when channel_up & check_en_i. Any state → IDLE when channel_up=0 or check_en_i=0.
  - Leaving BODY this way increments err_cnt (aborted frame).
  - Leaving HEAD or DROP this way adds no count.
- HEAD, on valid beat:
  - Tag mismatch, tkeep≠all-ones, or tlast=1: err_cnt+1, go DROP. If tlast=1, go HEAD instead.
  - Otherwise latch rx_seq and set index=1, go BODY.
  - Sequence check, done only on a good header: if seq_synced and rx_seq≠exp_seq, seq_err_cnt+1.
  - Whether or not seq matched, exp_seq ← rx_seq+1 (wraps 0xFFFF→0) and seq_synced←1. The frame is still checked; a seq error alone does not fail the frame.
- BODY, on valid beat:
  - Compare against {rx_seq, index}, tkeep all-ones, and tlast == (index==FRAME_LEN-1).
  - First mismatch: err_cnt+1, go DROP; if that beat has tlast, go HEAD.
  - Match with tlast: frame_cnt+1, frame_ok_o pulses, go HEAD.
  - Match without tlast: index+1.
- DROP: discard beats until a valid tlast, then go HEAD. At most one err_cnt increment per frame.
- Beats with tvalid=0 are ignored in all states; state and index hold.
- Latency: counters, err_flag_o and frame_ok_o update on the clock edge after the triggering beat (registered outputs).
- Counters saturate at all-ones; no wrap.
- err_flag_o is set in the same cycle as any err_cnt or seq_err_cnt increment. It is cleared only by clr_i or reset.
- clr_i: zeroes all counters, err_flag_o and seq_synced. It wins over a same-cycle increment; FSM state is unaffected.
- Reset mid-frame returns to IDLE immediately (asynchronous). The next frame after reset is seq-synced without error.

Test Plan:
1. FRAME_LEN=4; send seq 0,1,2 well-formed frames back-to-back, tvalid gaps inserted → frame_cnt_o=3, err_cnt_o=0, seq_err_cnt_o=0, three frame_ok_o pulses, err_flag_o=0.
2. FRAME_LEN=4, seq 5; corrupt word 2 to 0x0005_0007 → err_cnt_o=1, frame_cnt_o=0, state_o=3 until tlast, then 1; err_flag_o=1.
3. FRAME_LEN=4; tlast on word 2 (early), then a good frame seq 6 → err_cnt_o=1, state returns to HEAD with no DROP, following frame counted, frame_cnt_o=1.
4. Send seq 10 then seq 12, both well-formed → seq_err_cnt_o=1, frame_cnt_o=2, err_cnt_o=0; then seq 0xFFFF followed by 0x0000 → no further seq error after the initial resync.
5. Drop channel_up during BODY (word 1 of 4) → err_cnt_o=1, state_o=0. Restore channel_up; send seq 0x0100 → counted, no seq error.
6. Preset err_cnt_o to all-ones via forced errors with CNT_WIDTH=4 → holds at 15. Assert clr_i in the same cycle as an error beat → all counters 0, err_flag_o=0.
